pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32 pipeline. It drives stall, flush, pc_src, new_pc and forward_a/forward_b into the IF, ID and EX stages. It detects load-use and instruction-memory-wait hazards, redirects on taken branches, and handles a halt/drain request. It keeps saturating performance counters for stalls and flushes.

---
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Drives stall/flush/redirect into IF, ID and EX, selects EX operand
// forwarding, manages halt/drain and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int IMEM_TIMEOUT      = 16,
  parameter int DRAIN_CYCLES      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_ex_valid,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rd_addr,
  input  logic [4:0]  id_ex_rs1_addr,
  input  logic [4:0]  id_ex_rs2_addr,
  input  logic        ex_mem_valid,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  ex_mem_rd_addr,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_rd_addr,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_ready,
  input  logic        halt_req,
  output logic        stall,
  output logic        flush,
  output logic        pc_src,
  output logic [31:0] new_pc,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        halted,
  output logic        imem_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    IMEM_WAIT  = 3'd2,
    DRAIN      = 3'd3,
    HALTED     = 3'd4
  } state_t;

  // Terminal counter values: the cycle spent in RUN detecting the event is
  // the first stalled cycle, so the dedicated state lasts one cycle less.
  localparam logic [2:0] LOAD_LAST  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
  localparam logic [7:0] WD_LAST    = 8'(IMEM_TIMEOUT - 1);

  state_t      state_reg;
  logic [2:0]  count_reg;
  logic [7:0]  watchdog_reg;
  logic        load_use;
  logic        redirect;

  // Forwarding source: the younger producer (EX/MEM) wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_mem_valid && ex_mem_reg_write && (ex_mem_rd_addr != 5'd0) &&
        (ex_mem_rd_addr == rs))
      return 2'b10;
    else if (mem_wb_reg_write && (mem_wb_rd_addr != 5'd0) && (mem_wb_rd_addr == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign forward_a = fwd_sel(id_ex_rs1_addr);
  assign forward_b = fwd_sel(id_ex_rs2_addr);
  assign new_pc    = branch_target;

  assign load_use = if_id_valid && id_ex_valid && id_ex_mem_read &&
                    (id_ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == id_ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == id_ex_rd_addr)));

  // A resolved branch is honoured in every state except HALTED.
  assign redirect = branch_taken && (state_reg != HALTED);

  // Pipeline control: a redirect always beats a stall in the same cycle.
  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    pc_src = 1'b0;
    if (redirect) begin
      flush  = 1'b1;
      pc_src = 1'b1;
    end else begin
      case (state_reg)
        RUN:       stall = load_use || !imem_ready || halt_req;
        IMEM_WAIT: stall = !imem_ready;
        default:   stall = 1'b1;
      endcase
    end
  end

  // Sequencing FSM with registered status outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= RUN;
      count_reg    <= 3'd0;
      watchdog_reg <= 8'd0;
      halted       <= 1'b0;
      imem_timeout <= 1'b0;
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;

      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            state_reg <= RUN;
          end else if (load_use) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state_reg <= LOAD_STALL;
              count_reg <= 3'd1;
            end
          end else if (!imem_ready) begin
            state_reg    <= IMEM_WAIT;
            watchdog_reg <= 8'd1;
          end else if (halt_req) begin
            if (DRAIN_CYCLES > 1) begin
              state_reg <= DRAIN;
              count_reg <= 3'd1;
            end else begin
              state_reg <= HALTED;
              halted    <= 1'b1;
            end
          end
        end
        LOAD_STALL: begin
          if (branch_taken || (count_reg == LOAD_LAST))
            state_reg <= RUN;
          else
            count_reg <= count_reg + 3'd1;
        end
        IMEM_WAIT: begin
          if (branch_taken || imem_ready) begin
            state_reg <= RUN;
          end else if (watchdog_reg == WD_LAST) begin
            imem_timeout <= 1'b1;
            halted       <= 1'b1;
            state_reg    <= HALTED;
          end else begin
            watchdog_reg <= watchdog_reg + 8'd1;
          end
        end
        DRAIN: begin
          if (!halt_req) begin
            state_reg <= RUN;
          end else if (count_reg == DRAIN_LAST) begin
            state_reg <= HALTED;
            halted    <= 1'b1;
          end else begin
            count_reg <= count_reg + 3'd1;
          end
        end
        HALTED: begin
          if (!halt_req && !imem_timeout) begin
            state_reg <= RUN;
            halted    <= 1'b0;
          end
        end
        default: begin
          state_reg <= RUN;
          halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// literal expectations, then randomized traffic checked every cycle
// against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int LSC = 2;
  localparam int TO  = 4;
  localparam int DC  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_ex_valid, id_ex_mem_read;
  logic [4:0]  id_ex_rd_addr, id_ex_rs1_addr, id_ex_rs2_addr;
  logic        ex_mem_valid, ex_mem_reg_write;
  logic [4:0]  ex_mem_rd_addr;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd_addr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready, halt_req;
  logic        stall, flush, pc_src, halted, imem_timeout;
  logic [31:0] new_pc, stall_cycles;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] flush_count;

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(LSC),
    .IMEM_TIMEOUT(TO),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset),
    .if_id_valid(if_id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd_addr(id_ex_rd_addr), .id_ex_rs1_addr(id_ex_rs1_addr),
    .id_ex_rs2_addr(id_ex_rs2_addr),
    .ex_mem_valid(ex_mem_valid), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_rd_addr(ex_mem_rd_addr),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd_addr(mem_wb_rd_addr),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_ready(imem_ready), .halt_req(halt_req),
    .stall(stall), .flush(flush), .pc_src(pc_src), .new_pc(new_pc),
    .forward_a(forward_a), .forward_b(forward_b),
    .halted(halted), .imem_timeout(imem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_RUN = 0, M_LOAD = 1, M_IMEM = 2, M_DRAIN = 3, M_HALT = 4;
  int     m_mode;
  int     m_left;      // stalled cycles still owed in LOAD/DRAIN
  int     m_miss;      // consecutive fetch misses seen
  bit     m_to;
  longint m_stall_cnt;
  int     m_flush_cnt;
  bit     m_valid = 1'b0;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (ex_mem_valid && ex_mem_reg_write && ex_mem_rd_addr != 0 && ex_mem_rd_addr == rs)
      return 2'b10;
    if (mem_wb_reg_write && mem_wb_rd_addr != 0 && mem_wb_rd_addr == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  // Compare DUT against the model at every falling edge, then advance the
  // model with the inputs that the next rising edge will see.
  always @(negedge clk) begin
    bit lu, e_stall, e_flush;
    lu = if_id_valid && id_ex_valid && id_ex_mem_read && id_ex_rd_addr != 0 &&
         ((id_uses_rs1 && id_rs1_addr == id_ex_rd_addr) ||
          (id_uses_rs2 && id_rs2_addr == id_ex_rd_addr));
    e_flush = (m_mode != M_HALT) && branch_taken;
    if (e_flush)               e_stall = 1'b0;
    else if (m_mode == M_RUN)  e_stall = lu || !imem_ready || halt_req;
    else if (m_mode == M_IMEM) e_stall = !imem_ready;
    else                       e_stall = 1'b1;

    if (m_valid) begin
      chk("stall",        32'(stall),        32'(e_stall));
      chk("flush",        32'(flush),        32'(e_flush));
      chk("pc_src",       32'(pc_src),       32'(e_flush));
      chk("new_pc",       new_pc,            branch_target);
      chk("forward_a",    32'(forward_a),    32'(fwd(id_ex_rs1_addr)));
      chk("forward_b",    32'(forward_b),    32'(fwd(id_ex_rs2_addr)));
      chk("halted",       32'(halted),       32'(m_mode == M_HALT));
      chk("imem_timeout", 32'(imem_timeout), 32'(m_to));
      chk("stall_cycles", stall_cycles,      32'(m_stall_cnt));
      chk("flush_count",  32'(flush_count),  32'(m_flush_cnt));
    end

    if (!reset) begin
      m_mode = M_RUN; m_left = 0; m_miss = 0; m_to = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (e_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (e_flush && m_flush_cnt < 65535) m_flush_cnt++;
      case (m_mode)
        M_RUN: begin
          if (branch_taken) ;
          else if (lu) begin
            if (LSC > 1) begin m_mode = M_LOAD; m_left = LSC - 1; end
          end else if (!imem_ready) begin
            m_mode = M_IMEM; m_miss = 1;
          end else if (halt_req) begin
            if (DC > 1) begin m_mode = M_DRAIN; m_left = DC - 1; end
            else m_mode = M_HALT;
          end
        end
        M_LOAD: begin
          m_left--;
          if (branch_taken || m_left == 0) m_mode = M_RUN;
        end
        M_IMEM: begin
          if (branch_taken || imem_ready) m_mode = M_RUN;
          else begin
            m_miss++;
            if (m_miss == TO) begin m_to = 1'b1; m_mode = M_HALT; end
          end
        end
        M_DRAIN: begin
          if (!halt_req) m_mode = M_RUN;
          else begin
            m_left--;
            if (m_left == 0) m_mode = M_HALT;
          end
        end
        default: if (!halt_req && !m_to) m_mode = M_RUN;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_ex_valid = 0; id_ex_mem_read = 0; id_ex_rd_addr = 0; id_ex_rs1_addr = 0;
    id_ex_rs2_addr = 0; ex_mem_valid = 0; ex_mem_reg_write = 0; ex_mem_rd_addr = 0;
    mem_wb_reg_write = 0; mem_wb_rd_addr = 0; branch_taken = 0; branch_target = 0;
    imem_ready = 1; halt_req = 0;
  endtask

  task automatic reset_pulse();
    reset = 0;
    step();
    reset = 1;
  endtask

  task automatic load_use_inputs();
    if_id_valid = 1; id_uses_rs1 = 1; id_rs1_addr = 5;
    id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd_addr = 5;
  endtask

  int burst;

  initial begin
    idle();
    reset = 0;
    step(); step();
    reset = 1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    $display("reset: stall=%0b flush=%0b halted=%0b", stall, flush, halted);

    // forwarding priority
    id_ex_rs1_addr = 1; id_ex_rs2_addr = 1; ex_mem_valid = 1; ex_mem_reg_write = 1;
    ex_mem_rd_addr = 1; mem_wb_reg_write = 1; mem_wb_rd_addr = 1;
    #1 chk("fwd_exmem", 32'(forward_a), 32'd2);
    chk("fwd_exmem_b", 32'(forward_b), 32'd2);
    ex_mem_reg_write = 0;
    #1 chk("fwd_memwb", 32'(forward_a), 32'd1);
    ex_mem_rd_addr = 0; mem_wb_rd_addr = 0; id_ex_rs1_addr = 0;
    #1 chk("fwd_none", 32'(forward_a), 32'd0);
    $display("forwarding: last forward_a=%b", forward_a);
    idle();

    // load-use: two stalled cycles
    reset_pulse();
    load_use_inputs();
    #1 chk("lu_stall0", 32'(stall), 32'd1);
    step();
    #1 chk("lu_stall1", 32'(stall), 32'd1);
    idle();
    step();
    #1 chk("lu_release", 32'(stall), 32'd0);
    chk("lu_stall_cycles", stall_cycles, 32'd2);
    $display("load-use: stall_cycles=%0d", stall_cycles);

    // branch concurrent with load-use
    load_use_inputs();
    branch_taken = 1; branch_target = 32'h40;
    #1 chk("br_flush", 32'(flush), 32'd1);
    chk("br_pc_src", 32'(pc_src), 32'd1);
    chk("br_new_pc", new_pc, 32'h40);
    chk("br_stall", 32'(stall), 32'd0);
    step();
    idle();
    #1 chk("br_flush_count", 32'(flush_count), 32'd1);
    $display("branch: new_pc=%h flush_count=%0d", new_pc, flush_count);

    // imem wait of three cycles
    reset_pulse();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("imem_wait_stall", 32'(stall), 32'd1);
      step();
    end
    imem_ready = 1;
    #1 chk("imem_ready_stall", 32'(stall), 32'd0);
    step();
    // four misses -> fatal timeout
    imem_ready = 0;
    repeat (4) step();
    imem_ready = 1;
    #1 chk("to_flag", 32'(imem_timeout), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    step();
    #1 chk("to_persist", 32'(halted), 32'd1);
    $display("imem timeout: imem_timeout=%0b halted=%0b", imem_timeout, halted);
    reset_pulse();
    #1 chk("to_reset_flag", 32'(imem_timeout), 32'd0);
    chk("to_reset_halted", 32'(halted), 32'd0);

    // reset in the middle of IMEM_WAIT
    imem_ready = 0;
    step(); step();
    imem_ready = 1;
    reset_pulse();
    #1 chk("mid_imem_stall", 32'(stall), 32'd0);
    chk("mid_imem_cnt", stall_cycles, 32'd0);

    // halt / drain
    halt_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("drain_stall", 32'(stall), 32'd1);
      chk("drain_not_halted", 32'(halted), 32'd0);
      step();
    end
    #1 chk("halt_reached", 32'(halted), 32'd1);
    halt_req = 0;
    #1 chk("halt_stall", 32'(stall), 32'd1);
    step();
    #1 chk("resume_stall", 32'(stall), 32'd0);
    chk("resume_halted", 32'(halted), 32'd0);
    $display("halt: resumed halted=%0b stall=%0b", halted, stall);

    // reset in the middle of DRAIN
    halt_req = 1;
    step();
    halt_req = 0;
    reset_pulse();
    #1 chk("mid_drain_stall", 32'(stall), 32'd0);
    chk("mid_drain_cnt", stall_cycles, 32'd0);
    chk("mid_drain_flush", 32'(flush_count), 32'd0);

    // randomized traffic, checked by the model every cycle
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      reset            = ($urandom_range(0, 99) != 0);
      if_id_valid      = $urandom_range(0, 3) != 0;
      id_rs1_addr      = 5'($urandom_range(0, 3));
      id_rs2_addr      = 5'($urandom_range(0, 3));
      id_uses_rs1      = 1'($urandom);
      id_uses_rs2      = 1'($urandom);
      id_ex_valid      = $urandom_range(0, 3) != 0;
      id_ex_mem_read   = $urandom_range(0, 2) == 0;
      id_ex_rd_addr    = 5'($urandom_range(0, 3));
      id_ex_rs1_addr   = 5'($urandom_range(0, 3));
      id_ex_rs2_addr   = 5'($urandom_range(0, 3));
      ex_mem_valid     = 1'($urandom);
      ex_mem_reg_write = 1'($urandom);
      ex_mem_rd_addr   = 5'($urandom_range(0, 3));
      mem_wb_reg_write = 1'($urandom);
      mem_wb_rd_addr   = 5'($urandom_range(0, 3));
      branch_taken     = $urandom_range(0, 9) == 0;
      branch_target    = $urandom;
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      if (burst > 0) begin
        burst--;
        imem_ready = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        burst = $urandom_range(1, 6);
        imem_ready = 0;
      end else begin
        imem_ready = $urandom_range(0, 9) != 0;
      end
    end
    $display("random: 4000 cycles applied");
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
